layer_controller: RTL and testbench

//  Sequences one fully-connected layer of neuron instances through an inference pass.

---
 rtl/layer_controller.sv | 204 ++++++++++++++++++++
 tb/tb_layer_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_controller.sv
// layer_controller
//   Sequences one fully-connected layer through an inference pass: pulses
//   neuron_reset, streams NUM_INPUTS activations from a synchronous-read
//   buffer to every neuron, then collects each neuron's output into a
//   registered layer vector. A pass that does not see every neuron report
//   within TIMEOUT_CYCLES wait cycles ends in a sticky error.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset
//   start            request one pass (sampled only in IDLE)
//   busy             high in every state except IDLE
//   done             1-cycle pulse, all neuron outputs captured
//   error            sticky wait timeout, cleared by an accepted start
//   in_addr          input buffer read address
//   in_data          buffer read data, valid one cycle after in_addr
//   neuron_reset     clears neuron accumulators (active-high)
//   neuron_in        activation broadcast to all neurons
//   neuron_valid     qualifies neuron_in
//   neuron_out_valid per-neuron output-valid strobes
//   neuron_out       neuron outputs, neuron n at [n*DATA_WIDTH +: DATA_WIDTH]
//   layer_out        captured neuron outputs, same packing
//   layer_out_valid  layer_out holds a complete pass
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_CLEAR  | neuron_reset pulse, address 0 presented to the buffer
// S_STREAM | addresses 1..NUM_INPUTS-1 issued, activations drain out
// S_WAIT   | capturing neuron outputs, timeout timer running
// S_DONE   | done pulse, layer_out_valid set
// S_ERR    | timeout reported, partial captures left visible

module layer_controller #(
  parameter int NUM_INPUTS     = 16,
  parameter int NUM_NEURONS    = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [ADDR_WIDTH-1:0]             in_addr,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              neuron_reset,
  output logic [DATA_WIDTH-1:0]             neuron_in,
  output logic                              neuron_valid,
  input  logic [NUM_NEURONS-1:0]            neuron_out_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_out,
  output logic                              layer_out_valid
);

  localparam int SCW = $clog2(NUM_INPUTS + 1);
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(NUM_INPUTS - 1);
  localparam logic [SCW-1:0]        STREAM_LOAD = SCW'(NUM_INPUTS);
  localparam logic [WCW-1:0]        WAIT_LOAD   = WCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Timers count down to a terminal count of zero.
  // str_left: NUM_INPUTS on the first STREAM cycle, 0 on the last one.
  // wait_left: TIMEOUT_CYCLES-1 on the first WAIT cycle, 0 on the last one.
  logic [SCW-1:0]                    str_left, str_left_nxt;
  logic [WCW-1:0]                    wait_left, wait_left_nxt;
  logic [NUM_NEURONS-1:0]            mask, mask_nxt, capture;
  logic [ADDR_WIDTH-1:0]             in_addr_nxt;
  logic                              error_nxt, lov_nxt;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_out_nxt;
  // High for one cycle after a real buffer address was presented; delays to
  // neuron_valid through the same output register as the data.
  logic                              rd_valid, rd_valid_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    str_left_nxt  = str_left;
    wait_left_nxt = wait_left;
    mask_nxt      = mask;
    capture       = '0;
    in_addr_nxt   = in_addr;
    error_nxt     = error;
    lov_nxt       = layer_out_valid;
    layer_out_nxt = layer_out;
    rd_valid_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt     = S_CLEAR;
          in_addr_nxt   = '0;
          mask_nxt      = '0;
          error_nxt     = 1'b0;
          lov_nxt       = 1'b0;
          layer_out_nxt = '0;
        end
      end

      S_CLEAR: begin
        state_nxt    = S_STREAM;
        str_left_nxt = STREAM_LOAD;
        rd_valid_nxt = 1'b1;
        in_addr_nxt  = (in_addr == LAST_ADDR) ? in_addr : in_addr + ADDR_WIDTH'(1);
      end

      S_STREAM: begin
        // Address k+1 is issued on STREAM cycle k; the final two cycles only
        // drain the buffer latency and the output register.
        rd_valid_nxt = (str_left > SCW'(1));
        in_addr_nxt  = (in_addr == LAST_ADDR) ? in_addr : in_addr + ADDR_WIDTH'(1);
        if (str_left == '0) begin
          state_nxt     = S_WAIT;
          wait_left_nxt = WAIT_LOAD;
        end else begin
          str_left_nxt = str_left - SCW'(1);
        end
      end

      S_WAIT: begin
        capture  = neuron_out_valid & ~mask;
        mask_nxt = mask | capture;
        for (int n = 0; n < NUM_NEURONS; n++) begin
          if (capture[n]) begin
            layer_out_nxt[n*DATA_WIDTH +: DATA_WIDTH] = neuron_out[n*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        // Completion is tested first so a final capture on the timeout cycle
        // still finishes cleanly.
        if (&mask_nxt) begin
          state_nxt = S_DONE;
          lov_nxt   = 1'b1;
        end else if (wait_left == '0) begin
          state_nxt = S_ERR;
          error_nxt = 1'b1;
        end else begin
          wait_left_nxt = wait_left - WCW'(1);
        end
      end

      S_DONE: state_nxt = S_IDLE;

      S_ERR: state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_left        <= '0;
      wait_left       <= '0;
      mask            <= '0;
      in_addr         <= '0;
      error           <= 1'b0;
      layer_out_valid <= 1'b0;
      layer_out       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      neuron_reset    <= 1'b0;
      rd_valid        <= 1'b0;
      neuron_valid    <= 1'b0;
      neuron_in       <= '0;
    end else begin
      str_left        <= str_left_nxt;
      wait_left       <= wait_left_nxt;
      mask            <= mask_nxt;
      in_addr         <= in_addr_nxt;
      error           <= error_nxt;
      layer_out_valid <= lov_nxt;
      layer_out       <= layer_out_nxt;
      busy            <= (state_nxt != S_IDLE);
      done            <= (state_nxt == S_DONE);
      neuron_reset    <= (state_nxt == S_CLEAR);
      rd_valid        <= rd_valid_nxt;
      neuron_valid    <= rd_valid;
      neuron_in       <= rd_valid ? in_data : '0;
    end
  end

endmodule

// File: tb/tb_layer_controller.sv
// tb_layer_controller
//   Directed and randomized passes through layer_controller. Cycle 0 of a
//   pass is the IDLE cycle in which start is sampled; every output is
//   predicted per cycle from the pass timeline and a per-pass capture model.

module tb_layer_controller;

  localparam int N  = 16;
  localparam int NN = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int T  = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            busy, done, error;
  logic [AW-1:0]   in_addr;
  logic [DW-1:0]   in_data;
  logic            neuron_reset;
  logic [DW-1:0]   neuron_in;
  logic            neuron_valid;
  logic [NN-1:0]   nvalid;
  logic [NN*DW-1:0] nout;
  logic [NN*DW-1:0] layer_out;
  logic            layer_out_valid;

  layer_controller #(
    .NUM_INPUTS(N), .NUM_NEURONS(NN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .in_addr(in_addr), .in_data(in_data), .neuron_reset(neuron_reset),
    .neuron_in(neuron_in), .neuron_valid(neuron_valid),
    .neuron_out_valid(nvalid), .neuron_out(nout),
    .layer_out(layer_out), .layer_out_valid(layer_out_valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read activation buffer.
  logic [DW-1:0] mem [N];
  always @(posedge clk) in_data <= mem[in_addr];

  int checks = 0;
  int errors = 0;

  // Strobe schedule for the next pass: wait-cycle index of the first and
  // second strobe (-1 = none), and a stray strobe on a pass cycle index
  // before WAIT (-1 = none).
  int            sw[NN];
  int            sw2[NN];
  int            stray[NN];
  logic [DW-1:0] sv[NN];
  logic [DW-1:0] sv2[NN];

  logic             prev_err;
  logic             prev_lov;
  logic [NN*DW-1:0] prev_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sched();
    for (int n = 0; n < NN; n++) begin
      sw[n] = -1; sw2[n] = -1; stray[n] = -1; sv[n] = '0; sv2[n] = '0;
    end
  endtask

  task automatic drive_neurons(input int i);
    for (int n = 0; n < NN; n++) begin
      nvalid[n] = 1'b0;
      nout[n*DW +: DW] = DW'($urandom);
      if (i == stray[n]) nvalid[n] = 1'b1;
      if (sw[n] >= 0 && i == N + 3 + sw[n]) begin
        nvalid[n] = 1'b1; nout[n*DW +: DW] = sv[n];
      end
      if (sw2[n] >= 0 && i == N + 3 + sw2[n]) begin
        nvalid[n] = 1'b1; nout[n*DW +: DW] = sv2[n];
      end
    end
  endtask

  task automatic idle(input int k);
    for (int c = 0; c < k; c++) begin
      start  = 1'b0;
      nvalid = NN'($urandom);
      for (int n = 0; n < NN; n++) nout[n*DW +: DW] = DW'($urandom);
      @(negedge clk);
      chk("idle_busy",      64'(busy), 64'(0));
      chk("idle_done",      64'(done), 64'(0));
      chk("idle_nvalid",    64'(neuron_valid), 64'(0));
      chk("idle_nreset",    64'(neuron_reset), 64'(0));
      chk("idle_error",     64'(error), 64'(prev_err));
      chk("idle_lov",       64'(layer_out_valid), 64'(prev_lov));
      chk("idle_layer_out", 64'(layer_out), 64'(prev_lo));
      @(posedge clk); #1;
    end
  endtask

  // One pass from the IDLE cycle that accepts start up to its DONE/ERR cycle.
  task automatic run_pass(input bit hold);
    logic [NN-1:0]    m;
    logic [NN*DW-1:0] lo;
    bit               complete;
    int               wd, last, ea;

    m = '0; lo = '0; complete = 1'b0; wd = 0;
    for (int w = 0; w < T && !complete; w++) begin
      for (int n = 0; n < NN; n++) begin
        if (!m[n]) begin
          if (sw[n] == w) begin
            lo[n*DW +: DW] = sv[n]; m[n] = 1'b1;
          end else if (sw2[n] == w) begin
            lo[n*DW +: DW] = sv2[n]; m[n] = 1'b1;
          end
        end
      end
      if (&m) begin
        complete = 1'b1; wd = w;
      end
    end
    last = complete ? N + 4 + wd : N + 3 + T;

    for (int i = 0; i <= last; i++) begin
      start = (i == 0 || hold) ? 1'b1 : 1'($urandom_range(0, 1));
      drive_neurons(i);
      @(negedge clk);
      chk("busy",         64'(busy), 64'(i >= 1));
      chk("neuron_reset", 64'(neuron_reset), 64'(i == 1));
      if (i >= 1) begin
        ea = (i - 1 < N - 1) ? i - 1 : N - 1;
        chk("in_addr", 64'(in_addr), 64'(ea));
      end
      chk("neuron_valid", 64'(neuron_valid), 64'(i >= 3 && i <= N + 2));
      if (i >= 3 && i <= N + 2) chk("neuron_in", 64'(neuron_in), 64'(mem[i-3]));
      chk("done", 64'(done), 64'(complete && i == last));
      if (i == 0) begin
        chk("error_prev",     64'(error), 64'(prev_err));
        chk("lov_prev",       64'(layer_out_valid), 64'(prev_lov));
        chk("layer_out_prev", 64'(layer_out), 64'(prev_lo));
      end else begin
        chk("error", 64'(error), 64'(!complete && i == last));
        chk("lov",   64'(layer_out_valid), 64'(complete && i == last));
      end
      if (i == 1)    chk("layer_out_cleared", 64'(layer_out), 64'(0));
      if (i == last) chk("layer_out_final",   64'(layer_out), 64'(lo));
      @(posedge clk); #1;
    end
    prev_err = !complete;
    prev_lov = complete;
    prev_lo  = lo;
  endtask

  initial begin
    int r;
    reset = 1'b0; start = 1'b0; nvalid = '0; nout = '0;
    for (int k = 0; k < N; k++) mem[k] = DW'(k + 1);
    clear_sched();

    // Reset state.
    #12;
    chk("rst_busy",      64'(busy), 64'(0));
    chk("rst_done",      64'(done), 64'(0));
    chk("rst_error",     64'(error), 64'(0));
    chk("rst_in_addr",   64'(in_addr), 64'(0));
    chk("rst_nreset",    64'(neuron_reset), 64'(0));
    chk("rst_neuron_in", 64'(neuron_in), 64'(0));
    chk("rst_nvalid",    64'(neuron_valid), 64'(0));
    chk("rst_layer_out", 64'(layer_out), 64'(0));
    chk("rst_lov",       64'(layer_out_valid), 64'(0));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    prev_err = 1'b0; prev_lov = 1'b0; prev_lo = '0;
    idle(2);

    // Neurons report at wait cycles 3,3,5,9.
    sw[0] = 3; sw[1] = 3; sw[2] = 5; sw[3] = 9;
    sv[0] = 8'h11; sv[1] = 8'h22; sv[2] = 8'h33; sv[3] = 8'h44;
    run_pass(1'b0);
    idle(1);
    chk("t2_layer_out", 64'(layer_out), 64'h44332211);
    chk("t2_lov",       64'(layer_out_valid), 64'(1));

    // Neuron 2 silent: timeout with partial captures.
    clear_sched();
    sw[0] = 1; sw[1] = 2; sw[3] = 4;
    sv[0] = 8'ha1; sv[1] = 8'hb2; sv[2] = 8'hc3; sv[3] = 8'hd4;
    run_pass(1'b0);
    idle(1);
    chk("t3_layer_out", 64'(layer_out), 64'hd400b2a1);
    chk("t3_error",     64'(error), 64'(1));
    chk("t3_lov",       64'(layer_out_valid), 64'(0));

    // Final capture on the last wait cycle: completion beats timeout.
    clear_sched();
    sw[0] = 0; sw[1] = 0; sw[2] = 0; sw[3] = T - 1;
    sv[0] = 8'h5a; sv[1] = 8'h6b; sv[2] = 8'h7c; sv[3] = 8'h8d;
    run_pass(1'b0);
    idle(1);
    chk("edge_error", 64'(error), 64'(0));
    chk("edge_lov",   64'(layer_out_valid), 64'(1));

    // start held high: one pass, next one begins in the IDLE cycle after DONE.
    clear_sched();
    sw[0] = 0; sw[1] = 1; sw[2] = 2; sw[3] = 3;
    sv[0] = 8'h01; sv[1] = 8'h02; sv[2] = 8'h03; sv[3] = 8'h04;
    run_pass(1'b1);
    run_pass(1'b1);
    idle(1);

    // Reset mid-STREAM at in_addr 7.
    clear_sched();
    start = 1'b1; nvalid = '0;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("abort_in_addr", 64'(in_addr), 64'(7));
    chk("abort_busy",    64'(busy), 64'(1));
    #1 reset = 1'b0;
    #1;
    chk("abort_busy0",    64'(busy), 64'(0));
    chk("abort_in_addr0", 64'(in_addr), 64'(0));
    chk("abort_nvalid0",  64'(neuron_valid), 64'(0));
    chk("abort_nin0",     64'(neuron_in), 64'(0));
    chk("abort_lo0",      64'(layer_out), 64'(0));
    @(posedge clk);
    @(negedge clk);
    chk("abort_done0", 64'(done), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    prev_err = 1'b0; prev_lov = 1'b0; prev_lo = '0;
    idle(2);
    sw[0] = 2; sw[1] = 4; sw[2] = 6; sw[3] = 8;
    sv[0] = 8'hf0; sv[1] = 8'he1; sv[2] = 8'hd2; sv[3] = 8'hc3;
    run_pass(1'b0);
    idle(1);

    // Neuron 1 strobes twice; only the first value is kept.
    clear_sched();
    sw[0] = 2; sw[1] = 1; sw[2] = 4; sw[3] = 6;
    sw2[1] = 3;
    sv[0] = 8'h10; sv[1] = 8'h05; sv[2] = 8'h30; sv[3] = 8'h40; sv2[1] = 8'h09;
    stray[2] = 5;
    run_pass(1'b0);
    idle(1);
    chk("t6_slot1", 64'(layer_out[DW +: DW]), 64'h05);

    // Randomized passes.
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < N; k++) mem[k] = DW'($urandom);
      clear_sched();
      for (int n = 0; n < NN; n++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      sw[n] = -1;
        else if (r == 1) sw[n] = $urandom_range(T - 2, T + 2);
        else             sw[n] = $urandom_range(0, 20);
        sv[n] = DW'($urandom);
        if (sw[n] >= 0 && $urandom_range(0, 2) == 0) begin
          sw2[n] = sw[n] + 1 + $urandom_range(0, 10);
          sv2[n] = DW'($urandom);
        end
        if ($urandom_range(0, 1) == 1) stray[n] = $urandom_range(1, N + 2);
      end
      run_pass(1'($urandom_range(0, 1)));
      idle($urandom_range(1, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
